// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment driver for the digital clock.
// Snapshots h:m:s once per frame, converts to BCD and scans one digit per SCAN_DIV cycles.
module clock_display_scan #(
    parameter int SCAN_DIV     = 1,
    parameter int BLINK_FRAMES = 84
) (
    input  logic       clk_1KHZ,
    input  logic       rst_n,
    input  logic [6:0] hour_in,
    input  logic [6:0] min_in,
    input  logic [6:0] sec_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    logic [PRE_W-1:0]  pre_reg, pre_next;
    logic [2:0]        idx_reg, idx_next;
    logic [6:0]        snap_h_reg, snap_h_next;
    logic [6:0]        snap_m_reg, snap_m_next;
    logic [6:0]        snap_s_reg, snap_s_next;
    logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
    logic              blink_reg, blink_next;
    logic [6:0]        seg_reg, seg_next;
    logic              dp_reg, dp_next;
    logic [5:0]        an_reg, an_next;
    logic              frame_tick_reg, frame_tick_next;

    logic       pre_wrap, boundary;
    logic [7:0] bcd_h, bcd_m, bcd_s;
    logic [3:0] digit;
    logic       field_ok;

    // Compare/subtract chain; each stage narrows the remainder so every bit is consumed.
    // Exact for 0..79, which covers every value that is not shown as a dash.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [5:0] r6;
        logic [4:0] r5;
        logic [3:0] r4;
        logic [3:0] t;
        t  = 4'd0;
        r6 = 6'(v);
        if (v >= 7'd40) begin
            r6 = 6'(v - 7'd40);
            t  = t + 4'd4;
        end
        r5 = 5'(r6);
        if (r6 >= 6'd20) begin
            r5 = 5'(r6 - 6'd20);
            t  = t + 4'd2;
        end
        r4 = 4'(r5);
        if (r5 >= 5'd10) begin
            r4 = 4'(r5 - 5'd10);
            t  = t + 4'd1;
        end
        return {t, r4};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_OFF;
        endcase
    endfunction

    assign bcd_h = to_bcd(snap_h_reg);
    assign bcd_m = to_bcd(snap_m_reg);
    assign bcd_s = to_bcd(snap_s_reg);

    assign pre_wrap = (pre_reg == PRE_LAST);
    assign boundary = pre_wrap && (idx_reg == 3'd5);

    always_comb begin
        pre_next        = pre_wrap ? '0 : pre_reg + 1'b1;
        idx_next        = idx_reg;
        snap_h_next     = snap_h_reg;
        snap_m_next     = snap_m_reg;
        snap_s_next     = snap_s_reg;
        fcnt_next       = fcnt_reg;
        blink_next      = blink_reg;
        frame_tick_next = boundary;
        if (pre_wrap) begin
            idx_next = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
        end
        if (boundary) begin
            snap_h_next = hour_in;
            snap_m_next = min_in;
            snap_s_next = sec_in;
            if (fcnt_reg == FCNT_LAST) begin
                fcnt_next  = '0;
                blink_next = ~blink_reg;
            end else begin
                fcnt_next = fcnt_reg + 1'b1;
            end
        end
    end

    // Output registers decode the pre-edge index so seg and an switch together.
    always_comb begin
        digit    = 4'd0;
        field_ok = 1'b1;
        case (idx_reg)
            3'd0:    begin digit = bcd_s[3:0]; field_ok = (snap_s_reg <= 7'd59); end
            3'd1:    begin digit = bcd_s[7:4]; field_ok = (snap_s_reg <= 7'd59); end
            3'd2:    begin digit = bcd_m[3:0]; field_ok = (snap_m_reg <= 7'd59); end
            3'd3:    begin digit = bcd_m[7:4]; field_ok = (snap_m_reg <= 7'd59); end
            3'd4:    begin digit = bcd_h[3:0]; field_ok = (snap_h_reg <= 7'd23); end
            3'd5:    begin digit = bcd_h[7:4]; field_ok = (snap_h_reg <= 7'd23); end
            default: begin digit = 4'd15;      field_ok = 1'b1;                   end
        endcase
        seg_next = field_ok ? seg_code(digit) : SEG_DASH;
        dp_next  = ~(blink_reg && ((idx_reg == 3'd2) || (idx_reg == 3'd4)));
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_an
        assign an_next[gi] = (idx_reg != 3'(gi));
    end

    always_ff @(posedge clk_1KHZ or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg        <= '0;
            idx_reg        <= 3'd0;
            snap_h_reg     <= 7'd0;
            snap_m_reg     <= 7'd0;
            snap_s_reg     <= 7'd0;
            fcnt_reg       <= '0;
            blink_reg      <= 1'b0;
            seg_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
            an_reg         <= 6'b111111;
            frame_tick_reg <= 1'b0;
        end else begin
            pre_reg        <= pre_next;
            idx_reg        <= idx_next;
            snap_h_reg     <= snap_h_next;
            snap_m_reg     <= snap_m_next;
            snap_s_reg     <= snap_s_next;
            fcnt_reg       <= fcnt_next;
            blink_reg      <= blink_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan: one fast-blink instance (SCAN_DIV=1, BLINK_FRAMES=2)
// and one slow-scan instance (SCAN_DIV=4) sharing clock, reset and inputs.
module tb_clock_display_scan;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000, SD = 7'b0111111;

    typedef struct packed {
        logic [6:0]      h;
        logic [6:0]      m;
        logic [6:0]      s;
        logic [5:0][6:0] exp;   // written hour-tens first, so exp[0] is sec ones
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] hour = 7'd0, mins = 7'd0, sec = 7'd0;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, ft_a, ft_b;
    logic [5:0] an_a, an_b;

    int tests_run = 0;
    int tests_failed = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(1), .BLINK_FRAMES(2)) dut_a (
        .clk_1KHZ(clk), .rst_n(rst_n), .hour_in(hour), .min_in(mins), .sec_in(sec),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a)
    );

    clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(84)) dut_b (
        .clk_1KHZ(clk), .rst_n(rst_n), .hour_in(hour), .min_in(mins), .sec_in(sec),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(ft_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ft_a && n < 40);
        check({name, "_tick"}, {31'd0, ft_a}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [5:0][6:0] exp);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("%s_an%0d", tag, k), {26'd0, an_a}, {26'd0, ~(6'b1 << k)});
            check($sformatf("%s_seg%0d", tag, k), {25'd0, seg_a}, {25'd0, exp[k]});
        end
        $display("[TB] frame %s checked", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{7'd12, 7'd34, 7'd56, {S1, S2, S3, S4, S5, S6}};
        vecs[1] = '{7'd5,  7'd60, 7'd7,  {S0, S5, SD, SD, S0, S7}};
        vecs[2] = '{7'd23, 7'd59, 7'd59, {S2, S3, S5, S9, S5, S9}};
        vecs[3] = '{7'd0,  7'd0,  7'd0,  {S0, S0, S0, S0, S0, S0}};
        vecs[4] = '{7'd24, 7'd70, 7'd99, {SD, SD, SD, SD, SD, SD}};
        vecs[5] = '{7'd19, 7'd8,  7'd41, {S1, S9, S0, S8, S4, S1}};
        vecs[6] = '{7'd23, 7'd60, 7'd60, {S2, S3, SD, SD, SD, SD}};
        vecs[7] = '{7'd12, 7'd34, 7'd56, {S1, S2, S3, S4, S5, S6}};

        // Reset state, with live inputs already non-zero
        hour = 7'd12; mins = 7'd34; sec = 7'd56;
        step(); step();
        check("rst_an_a",  {26'd0, an_a},  {26'd0, 6'b111111});
        check("rst_seg_a", {25'd0, seg_a}, {25'd0, 7'b1111111});
        check("rst_dp_a",  {31'd0, dp_a},  32'd1);
        check("rst_ft_a",  {31'd0, ft_a},  32'd0);
        check("rst_an_b",  {26'd0, an_b},  {26'd0, 6'b111111});
        check("rst_dp_b",  {31'd0, dp_b},  32'd1);

        // First frame after release shows the zero snapshot
        rst_n = 1'b1;
        check_frame("first", {S0, S0, S0, S0, S0, S0});
        check("first_tick", {31'd0, ft_a}, 32'd1);

        for (int v = 0; v < 8; v++) begin
            hour = vecs[v].h; mins = vecs[v].m; sec = vecs[v].s;
            wait_tick($sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Snapshot from vec7 (12:34:56) is live; change inputs at idx 2
        step();
        check("mid_seg0", {25'd0, seg_a}, {25'd0, S6});
        step();
        check("mid_seg1", {25'd0, seg_a}, {25'd0, S5});
        hour = 7'd12; mins = 7'd35; sec = 7'd0;
        step(); check("mid_seg2", {25'd0, seg_a}, {25'd0, S4});
        step(); check("mid_seg3", {25'd0, seg_a}, {25'd0, S3});
        step(); check("mid_seg4", {25'd0, seg_a}, {25'd0, S2});
        step(); check("mid_seg5", {25'd0, seg_a}, {25'd0, S1});
        check("mid_tick", {31'd0, ft_a}, 32'd1);
        check_frame("after_mid", {S1, S2, S3, S5, S0, S0});

        // Asynchronous reset mid-frame
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("async_an_a",  {26'd0, an_a},  {26'd0, 6'b111111});
        check("async_seg_a", {25'd0, seg_a}, {25'd0, 7'b1111111});
        check("async_dp_a",  {31'd0, dp_a},  32'd1);
        check("async_ft_a",  {31'd0, ft_a},  32'd0);
        check("async_an_b",  {26'd0, an_b},  {26'd0, 6'b111111});
        check("async_seg_b", {25'd0, seg_b}, {25'd0, 7'b1111111});
        step(); step();
        rst_n = 1'b1;

        // Blink phases (dut_a) and slow scan (dut_b) over 8 fast frames
        for (int n = 1; n <= 48; n++) begin
            int f, k;
            logic exp_dp;
            step();
            f = (n - 1) / 6;
            k = (n - 1) % 6;
            exp_dp = !((((f / 2) % 2) == 1) && (k == 2 || k == 4));
            check($sformatf("blink_dp_e%0d", n), {31'd0, dp_a}, {31'd0, exp_dp});
            check($sformatf("ft_a_e%0d", n), {31'd0, ft_a}, {31'd0, (n % 6) == 0});
            check($sformatf("an_b_e%0d", n), {26'd0, an_b}, {26'd0, ~(6'b1 << (((n - 1) / 4) % 6))});
            check($sformatf("ft_b_e%0d", n), {31'd0, ft_b}, {31'd0, (n % 24) == 0});
        end
        $display("[TB] blink and slow-scan sequence checked");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
